// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-client memory arbiter: state encoding,
// default outstanding-read depth and client identifiers.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    GRANT0 = 2'b01,
    GRANT1 = 2'b10
  } arb_state_t;

  localparam int MAX_OUT_DEFAULT = 4;

  localparam logic CLIENT0 = 1'b0;  // I-cache
  localparam logic CLIENT1 = 1'b1;  // D-cache

endpackage

// File: rtl/mem_arbiter_if.sv
// Client and memory-side signal bundle of the arbiter. The slave modport is
// the arbiter's view; the master modport is the surrounding system's view.
interface mem_arbiter_if;

  logic [31:0] i_c0_addr;
  logic        i_c0_ren;
  logic        i_c0_wen;
  logic [31:0] i_c0_wdata;
  logic        o_c0_ready;
  logic [31:0] o_c0_rdata;
  logic        o_c0_valid;

  logic [31:0] i_c1_addr;
  logic        i_c1_ren;
  logic        i_c1_wen;
  logic [31:0] i_c1_wdata;
  logic        o_c1_ready;
  logic [31:0] o_c1_rdata;
  logic        o_c1_valid;

  logic        i_mem_ready;
  logic [31:0] o_mem_addr;
  logic        o_mem_ren;
  logic        o_mem_wen;
  logic [31:0] o_mem_wdata;
  logic [31:0] i_mem_rdata;
  logic        i_mem_valid;

  logic        o_err;

  modport slave (
    input  i_c0_addr, i_c0_ren, i_c0_wen, i_c0_wdata,
    output o_c0_ready, o_c0_rdata, o_c0_valid,
    input  i_c1_addr, i_c1_ren, i_c1_wen, i_c1_wdata,
    output o_c1_ready, o_c1_rdata, o_c1_valid,
    input  i_mem_ready, i_mem_rdata, i_mem_valid,
    output o_mem_addr, o_mem_ren, o_mem_wen, o_mem_wdata,
    output o_err
  );

  modport master (
    output i_c0_addr, i_c0_ren, i_c0_wen, i_c0_wdata,
    input  o_c0_ready, o_c0_rdata, o_c0_valid,
    output i_c1_addr, i_c1_ren, i_c1_wen, i_c1_wdata,
    input  o_c1_ready, o_c1_rdata, o_c1_valid,
    output i_mem_ready, i_mem_rdata, i_mem_valid,
    input  o_mem_addr, o_mem_ren, o_mem_wen, o_mem_wdata,
    input  o_err
  );

endinterface

// File: rtl/mem_arbiter_ctr.sv
// Saturating up/down counter of read responses still owed by memory.
// Simultaneous inc and dec leave the count unchanged.
module arb_outstanding_ctr #(
  parameter int MAX = 4,
  parameter int CW  = $clog2(MAX + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc,
  input  logic          dec,
  output logic          full,
  output logic [CW-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (inc && !dec && count != CW'(MAX)) begin
      count <= count + CW'(1);
    end else if (dec && !inc && count != '0) begin
      count <= count - CW'(1);
    end
  end

  assign full = (count == CW'(MAX));

endmodule

// File: rtl/mem_arbiter.sv
// Two-client (I-cache / D-cache) arbiter onto one pipelined memory port,
// with fair tie-breaking and a cap on outstanding reads.
//   state  | meaning
//   IDLE   | no owner; memory port quiet; pick next owner
//   GRANT0 | client 0 owns the memory port
//   GRANT1 | client 1 owns the memory port
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MAX_OUT = MAX_OUT_DEFAULT
) (
  input logic          i_clk,
  input logic          i_rst,
  mem_arbiter_if.slave bus
);

  localparam int CW = $clog2(MAX_OUT + 1);

  arb_state_t  state_q, state_d;
  logic        last_gnt_q, last_gnt_d;
  logic        err_q;

  logic        granted;
  logic        owner;
  logic        own_ren, own_wen;
  logic [31:0] own_addr, own_wdata;
  logic        c0_req, c1_req;

  logic          full, inc, dec;
  logic [CW-1:0] count;
  logic          rd_allow, valid_ok, own_ready;

  arb_outstanding_ctr #(.MAX(MAX_OUT), .CW(CW)) u_ctr (
    .clk   (i_clk),
    .rst   (i_rst),
    .inc   (inc),
    .dec   (dec),
    .full  (full),
    .count (count)
  );

  always_comb begin
    granted   = 1'b0;
    owner     = CLIENT0;
    own_ren   = 1'b0;
    own_wen   = 1'b0;
    own_addr  = '0;
    own_wdata = '0;
    case (state_q)
      GRANT0: begin
        granted   = 1'b1;
        owner     = CLIENT0;
        own_ren   = bus.i_c0_ren;
        own_wen   = bus.i_c0_wen;
        own_addr  = bus.i_c0_addr;
        own_wdata = bus.i_c0_wdata;
      end
      GRANT1: begin
        granted   = 1'b1;
        owner     = CLIENT1;
        own_ren   = bus.i_c1_ren;
        own_wen   = bus.i_c1_wen;
        own_addr  = bus.i_c1_addr;
        own_wdata = bus.i_c1_wdata;
      end
      default: ;
    endcase
  end

  // A read at the cap may still go out when a response frees a slot this cycle.
  assign rd_allow  = own_ren && (!full || bus.i_mem_valid);
  assign valid_ok  = bus.i_mem_valid && granted && (count != '0);
  assign own_ready = bus.i_mem_ready && (rd_allow || own_wen);
  assign inc       = rd_allow && bus.i_mem_ready;
  assign dec       = valid_ok;

  assign bus.o_mem_addr  = own_addr;
  assign bus.o_mem_wdata = own_wdata;
  assign bus.o_mem_ren   = rd_allow;
  assign bus.o_mem_wen   = own_wen;

  assign bus.o_c0_ready = own_ready && granted && (owner == CLIENT0);
  assign bus.o_c1_ready = own_ready && granted && (owner == CLIENT1);
  assign bus.o_c0_valid = valid_ok && (owner == CLIENT0);
  assign bus.o_c1_valid = valid_ok && (owner == CLIENT1);
  assign bus.o_c0_rdata = bus.i_mem_rdata;
  assign bus.o_c1_rdata = bus.i_mem_rdata;
  assign bus.o_err      = err_q;

  assign c0_req = bus.i_c0_ren || bus.i_c0_wen;
  assign c1_req = bus.i_c1_ren || bus.i_c1_wen;

  always_comb begin
    state_d    = state_q;
    last_gnt_d = last_gnt_q;
    case (state_q)
      IDLE: begin
        if (c0_req && c1_req) begin
          state_d = (last_gnt_q == CLIENT0) ? GRANT1 : GRANT0;
        end else if (c0_req) begin
          state_d = GRANT0;
        end else if (c1_req) begin
          state_d = GRANT1;
        end
      end
      GRANT0, GRANT1: begin
        if (!own_ren && !own_wen &&
            (count == '0 || (count == CW'(1) && dec))) begin
          state_d    = IDLE;
          last_gnt_d = owner;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= IDLE;
      last_gnt_q <= CLIENT0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
      if (bus.i_mem_valid && !valid_ok) begin
        err_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a per-cycle vector table for grant/tie
// behaviour, plus hand sequences for bursts, the read cap, stalls and reset.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  logic i_clk = 1'b0;
  logic i_rst = 1'b1;
  always #5 i_clk = ~i_clk;

  mem_arbiter_if bus ();

  mem_arbiter #(.MAX_OUT(4)) dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (bus)
  );

  int n_chk = 0;
  int n_err = 0;

  // in  = {c0_ren, c0_wen, c1_ren, c1_wen, mem_ready, mem_valid}
  // out = {c0_ready, c1_ready, mem_ren, mem_wen, c0_valid, c1_valid}
  typedef struct {
    logic [5:0]  in;
    logic [31:0] rdata;
    logic [5:0]  out;
    logic [31:0] addr;
    logic [31:0] wdata;
    arb_state_t  state;
    logic [2:0]  cnt;
    logic        err;
  } vec_t;

  localparam int NV = 10;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.i_c0_addr   = 32'h0000_0100;
    bus.i_c0_ren    = 1'b0;
    bus.i_c0_wen    = 1'b0;
    bus.i_c0_wdata  = 32'h1234_5678;
    bus.i_c1_addr   = 32'h0000_0200;
    bus.i_c1_ren    = 1'b0;
    bus.i_c1_wen    = 1'b0;
    bus.i_c1_wdata  = 32'hDEAD_BEEF;
    bus.i_mem_ready = 1'b0;
    bus.i_mem_rdata = 32'h0;
    bus.i_mem_valid = 1'b0;
  endtask

  task automatic do_reset();
    i_rst = 1'b1;
    idle_inputs();
    next_cycle();
    next_cycle();
    i_rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [5:0] got;
    int acc_cyc [4];
    int n_acc, n_rsp, n_sent, peak;

    vecs[0] = '{6'b100110, 32'h0,  6'b000000, 32'h000, 32'h0,         GRANT1, 3'd0, 1'b0};
    vecs[1] = '{6'b100110, 32'h0,  6'b010100, 32'h200, 32'hDEAD_BEEF, GRANT1, 3'd0, 1'b0};
    vecs[2] = '{6'b100010, 32'h0,  6'b000000, 32'h200, 32'hDEAD_BEEF, IDLE,   3'd0, 1'b0};
    vecs[3] = '{6'b101010, 32'h0,  6'b000000, 32'h000, 32'h0,         GRANT0, 3'd0, 1'b0};
    vecs[4] = '{6'b101010, 32'h0,  6'b101000, 32'h100, 32'h1234_5678, GRANT0, 3'd1, 1'b0};
    vecs[5] = '{6'b001011, 32'h11, 6'b000010, 32'h100, 32'h1234_5678, IDLE,   3'd0, 1'b0};
    vecs[6] = '{6'b001010, 32'h0,  6'b000000, 32'h000, 32'h0,         GRANT1, 3'd0, 1'b0};
    vecs[7] = '{6'b001010, 32'h0,  6'b011000, 32'h200, 32'hDEAD_BEEF, GRANT1, 3'd1, 1'b0};
    vecs[8] = '{6'b000011, 32'h22, 6'b000001, 32'h200, 32'hDEAD_BEEF, IDLE,   3'd0, 1'b0};
    vecs[9] = '{6'b000011, 32'h33, 6'b000000, 32'h000, 32'h0,         IDLE,   3'd0, 1'b1};

    idle_inputs();
    #1;
    chk("rst_ready", 32'({bus.o_c0_ready, bus.o_c1_ready, bus.o_mem_ren, bus.o_mem_wen}), 32'h0);
    chk("rst_state", 32'(dut.state_q), 32'(IDLE));
    do_reset();

    // Tie after reset goes to c1; c1 write; handover via IDLE; tie then to c0.
    for (int i = 0; i < NV; i++) begin
      {bus.i_c0_ren, bus.i_c0_wen, bus.i_c1_ren, bus.i_c1_wen,
       bus.i_mem_ready, bus.i_mem_valid} = vecs[i].in;
      bus.i_mem_rdata = vecs[i].rdata;
      #3;
      got = {bus.o_c0_ready, bus.o_c1_ready, bus.o_mem_ren, bus.o_mem_wen,
             bus.o_c0_valid, bus.o_c1_valid};
      chk($sformatf("vec%0d_outs", i), 32'(got), 32'(vecs[i].out));
      chk($sformatf("vec%0d_addr", i), bus.o_mem_addr, vecs[i].addr);
      chk($sformatf("vec%0d_wdata", i), bus.o_mem_wdata, vecs[i].wdata);
      chk($sformatf("vec%0d_rdata0", i), bus.o_c0_rdata, vecs[i].rdata);
      chk($sformatf("vec%0d_rdata1", i), bus.o_c1_rdata, vecs[i].rdata);
      next_cycle();
      chk($sformatf("vec%0d_state", i), 32'(dut.state_q), 32'(vecs[i].state));
      chk($sformatf("vec%0d_cnt", i), 32'(dut.u_ctr.count), 32'(vecs[i].cnt));
      chk($sformatf("vec%0d_err", i), 32'(bus.o_err), 32'(vecs[i].err));
    end

    do_reset();
    chk("err_cleared_by_reset", 32'(bus.o_err), 32'h0);

    // c0 burst of four reads, memory answers two cycles after acceptance.
    n_acc = 0; n_rsp = 0; n_sent = 0; peak = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      bus.i_c0_ren    = (n_acc < 4);
      bus.i_c0_addr   = 32'h100 + 32'(4 * n_acc);
      bus.i_mem_ready = 1'b1;
      if (n_sent < n_acc && acc_cyc[n_sent] + 2 == cyc) begin
        bus.i_mem_valid = 1'b1;
        bus.i_mem_rdata = 32'hC0DE_0000 | (32'h100 + 32'(4 * n_sent));
        n_sent++;
      end else begin
        bus.i_mem_valid = 1'b0;
      end
      #3;
      chk("burst_c1_valid", 32'(bus.o_c1_valid), 32'h0);
      if (bus.o_c0_valid) begin
        chk("burst_rdata", bus.o_c0_rdata, 32'hC0DE_0000 | (32'h100 + 32'(4 * n_rsp)));
        n_rsp++;
      end
      if (bus.o_c0_ready && n_acc < 4) begin
        acc_cyc[n_acc] = cyc;
        n_acc++;
      end
      next_cycle();
      if (int'(dut.u_ctr.count) > peak) peak = int'(dut.u_ctr.count);
      if (n_rsp == 4 && dut.state_q == IDLE) break;
    end
    chk("burst_accepted", 32'(n_acc), 32'd4);
    chk("burst_responses", 32'(n_rsp), 32'd4);
    chk("burst_peak_cnt", 32'(peak), 32'd2);
    chk("burst_end_state", 32'(dut.state_q), 32'(IDLE));
    chk("burst_err", 32'(bus.o_err), 32'h0);

    // Read cap: four outstanding, fifth read waits for a response slot.
    do_reset();
    bus.i_c0_ren    = 1'b1;
    bus.i_mem_ready = 1'b1;
    next_cycle();
    for (int i = 0; i < 4; i++) begin
      #3;
      chk("cap_fill_ready", 32'(bus.o_c0_ready), 32'h1);
      next_cycle();
    end
    chk("cap_cnt_full", 32'(dut.u_ctr.count), 32'd4);
    for (int i = 0; i < 2; i++) begin
      #3;
      chk("cap_blocked_ready", 32'(bus.o_c0_ready), 32'h0);
      chk("cap_blocked_ren", 32'(bus.o_mem_ren), 32'h0);
      next_cycle();
      chk("cap_blocked_cnt", 32'(dut.u_ctr.count), 32'd4);
    end
    bus.i_mem_valid = 1'b1;
    bus.i_mem_rdata = 32'hAAAA_0001;
    #3;
    chk("cap_swap_ready", 32'(bus.o_c0_ready), 32'h1);
    chk("cap_swap_ren", 32'(bus.o_mem_ren), 32'h1);
    chk("cap_swap_valid", 32'(bus.o_c0_valid), 32'h1);
    next_cycle();
    chk("cap_swap_cnt", 32'(dut.u_ctr.count), 32'd4);
    bus.i_c0_ren = 1'b0;
    for (int i = 0; i < 4; i++) next_cycle();
    bus.i_mem_valid = 1'b0;
    chk("cap_drain_cnt", 32'(dut.u_ctr.count), 32'd0);
    chk("cap_drain_state", 32'(dut.state_q), 32'(IDLE));
    chk("cap_drain_err", 32'(bus.o_err), 32'h0);

    // Memory stall in GRANT0, then reset with two reads in flight.
    do_reset();
    bus.i_c0_ren    = 1'b1;
    bus.i_mem_ready = 1'b0;
    next_cycle();
    for (int i = 0; i < 5; i++) begin
      #3;
      chk("stall_ready", 32'(bus.o_c0_ready), 32'h0);
      chk("stall_ren", 32'(bus.o_mem_ren), 32'h1);
      chk("stall_addr", bus.o_mem_addr, 32'h100);
      next_cycle();
      chk("stall_cnt", 32'(dut.u_ctr.count), 32'd0);
      chk("stall_state", 32'(dut.state_q), 32'(GRANT0));
    end
    bus.i_mem_ready = 1'b1;
    next_cycle();
    next_cycle();
    chk("pre_rst_cnt", 32'(dut.u_ctr.count), 32'd2);
    i_rst = 1'b1;
    #1;
    chk("midrst_outs", 32'({bus.o_c0_ready, bus.o_c1_ready, bus.o_mem_ren, bus.o_mem_wen,
                            bus.o_c0_valid, bus.o_c1_valid}), 32'h0);
    chk("midrst_addr", bus.o_mem_addr, 32'h0);
    chk("midrst_wdata", bus.o_mem_wdata, 32'h0);
    chk("midrst_state", 32'(dut.state_q), 32'(IDLE));
    chk("midrst_cnt", 32'(dut.u_ctr.count), 32'd0);
    next_cycle();
    i_rst = 1'b0;
    bus.i_c0_ren    = 1'b0;
    bus.i_mem_valid = 1'b1;
    bus.i_mem_rdata = 32'h5555_0000;
    for (int i = 0; i < 2; i++) begin
      #3;
      chk("stray_valid", 32'({bus.o_c0_valid, bus.o_c1_valid}), 32'h0);
      next_cycle();
    end
    bus.i_mem_valid = 1'b0;
    chk("stray_err", 32'(bus.o_err), 32'h1);
    chk("stray_state", 32'(dut.state_q), 32'(IDLE));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
